// File: rtl/multicycle_ctrl.sv
// Multi-cycle control unit for the MIPS-subset CPU.
// Walks each instruction through FETCH/DECODE/EXEC/MEM/WB against a shared
// memory with a ready handshake, and drives the datapath control fields.
// State, latched opcode/funct and the wait counter are flops. Outputs are
// decoded from them, so each output shows in the cycle the FSM is in the
// state that owns it. The strobes that complete a memory request
// (ir/pc write in FETCH, the request drop and timeout pulse) are also
// qualified by mem_ready_i, so they land in the cycle the memory finishes.
// While rst_i is low every output is forced to 0.
module multicycle_ctrl #(
   parameter int OP_W         = 6,
   parameter int FUNCT_W      = 6,
   parameter int ALUOP_W      = 3,
   parameter int WAIT_W       = 4,
   parameter int MEM_WAIT_MAX = 15
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [OP_W-1:0]    instr_op_i,
   input  logic [FUNCT_W-1:0] instr_funct_i,
   input  logic               mem_ready_i,
   output logic               mem_req_o,
   output logic               ir_write_o,
   output logic               pc_write_o,
   output logic               pc_write_cond_o,
   output logic               RegWrite_o,
   output logic [ALUOP_W-1:0] ALU_op_o,
   output logic               ALUSrc_o,
   output logic [1:0]         RegDst_o,
   output logic               Branch_o,
   output logic [1:0]         BranchType_o,
   output logic [1:0]         Jump_o,
   output logic               MemRead_o,
   output logic               MemWrite_o,
   output logic [1:0]         MemToReg_o,
   output logic               illegal_o,
   output logic               timeout_o,
   output logic [2:0]         state_o
);

   typedef enum logic [2:0] {
      FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4
   } state_t;

   // Sequencing class of an instruction; j and jr share the jump path.
   typedef enum logic [2:0] {
      K_ALU, K_BRANCH, K_JUMP, K_JAL, K_LOAD, K_STORE, K_BAD
   } kind_t;

   typedef struct packed {
      logic [ALUOP_W-1:0] aluOp;
      logic               aluSrc;
      logic [1:0]         regDst;
      logic [1:0]         branchType;
      logic [1:0]         jump;
      logic [1:0]         memToReg;
   } fields_t;

   localparam logic [FUNCT_W-1:0] FUNCT_JR = FUNCT_W'(6'h08);
   localparam logic [WAIT_W-1:0]  WAIT_LIM = WAIT_W'(MEM_WAIT_MAX);

   // Every R-type funct is accepted; only jr changes the sequencing.
   function automatic kind_t kindOf(input logic [OP_W-1:0] op,
                                    input logic [FUNCT_W-1:0] funct);
      kind_t k;
      case (op)
         OP_W'(6'h00): k = (funct == FUNCT_JR) ? K_JUMP : K_ALU;
         OP_W'(6'h01), OP_W'(6'h04),
         OP_W'(6'h05), OP_W'(6'h06): k = K_BRANCH;
         OP_W'(6'h02): k = K_JUMP;
         OP_W'(6'h03): k = K_JAL;
         OP_W'(6'h08), OP_W'(6'h09), OP_W'(6'h0f): k = K_ALU;
         OP_W'(6'h23): k = K_LOAD;
         OP_W'(6'h2b): k = K_STORE;
         default:      k = K_BAD;
      endcase
      return k;
   endfunction

   // Datapath control fields for the latched instruction.
   function automatic fields_t fieldsOf(input logic [OP_W-1:0] op,
                                        input logic [FUNCT_W-1:0] funct);
      fields_t f;
      f = '0;
      case (op)
         OP_W'(6'h00): begin
            f.aluOp  = ALUOP_W'(3'b010);
            f.regDst = 2'd1;
            if (funct == FUNCT_JR) f.jump = 2'd2;
         end
         OP_W'(6'h01): begin f.aluOp = ALUOP_W'(3'b001); f.branchType = 2'd2; end
         OP_W'(6'h04): begin f.aluOp = ALUOP_W'(3'b001); f.branchType = 2'd0; end
         OP_W'(6'h05): begin f.aluOp = ALUOP_W'(3'b001); f.branchType = 2'd3; end
         OP_W'(6'h06): begin f.aluOp = ALUOP_W'(3'b001); f.branchType = 2'd1; end
         OP_W'(6'h02): f.jump = 2'd1;
         OP_W'(6'h03): begin f.jump = 2'd1; f.regDst = 2'd2; f.memToReg = 2'd2; end
         OP_W'(6'h08), OP_W'(6'h0f): begin f.aluOp = ALUOP_W'(3'b100); f.aluSrc = 1'b1; end
         OP_W'(6'h09): begin f.aluOp = ALUOP_W'(3'b101); f.aluSrc = 1'b1; end
         OP_W'(6'h23): begin f.aluOp = ALUOP_W'(3'b100); f.aluSrc = 1'b1; f.memToReg = 2'd1; end
         OP_W'(6'h2b): begin f.aluOp = ALUOP_W'(3'b100); f.aluSrc = 1'b1; end
         default:      f = '0;
      endcase
      return f;
   endfunction

   state_t               state, nextState;
   logic [OP_W-1:0]      opReg, nextOp;
   logic [FUNCT_W-1:0]   functReg, nextFunct;
   logic [WAIT_W-1:0]    waitCnt, nextWait;
   kind_t                curKind, incKind;
   fields_t              curFields;
   logic                 expired, fieldsActive;
   logic memReq, irWrite, pcWrite, pcWriteCond, regWrite, branch;
   logic memRead, memWrite, illegal, timeout;

   assign curKind      = kindOf(opReg, functReg);
   assign curFields    = fieldsOf(opReg, functReg);
   assign incKind      = kindOf(instr_op_i, instr_funct_i);
   assign expired      = (waitCnt == WAIT_LIM) && !mem_ready_i;
   assign fieldsActive = (state == EXEC) || (state == MEM) || (state == WB);

   // State, latched instruction and memory-wait counter.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state    <= FETCH;
         opReg    <= '0;
         functReg <= '0;
         waitCnt  <= '0;
      end else begin
         state    <= nextState;
         opReg    <= nextOp;
         functReg <= nextFunct;
         waitCnt  <= nextWait;
      end
   end

   // Next state, wait counting and per-state strobes.
   always_comb begin
      nextState   = state;
      nextWait    = '0;
      nextOp      = opReg;
      nextFunct   = functReg;
      memReq      = 1'b0;
      irWrite     = 1'b0;
      pcWrite     = 1'b0;
      pcWriteCond = 1'b0;
      regWrite    = 1'b0;
      branch      = 1'b0;
      memRead     = 1'b0;
      memWrite    = 1'b0;
      illegal     = 1'b0;
      timeout     = 1'b0;
      case (state)
         FETCH: begin
            memReq  = 1'b1;
            memRead = 1'b1;
            if (mem_ready_i) begin
               irWrite   = 1'b1;
               pcWrite   = 1'b1;
               nextState = DECODE;
            end else if (expired) begin
               // give up: drop the request and retry the fetch, PC unchanged
               memReq  = 1'b0;
               memRead = 1'b0;
               timeout = 1'b1;
            end else begin
               nextWait = waitCnt + 1'b1;
            end
         end
         DECODE: begin
            if (incKind == K_BAD) begin
               illegal   = 1'b1;
               nextState = FETCH;
            end else begin
               nextOp    = instr_op_i;
               nextFunct = instr_funct_i;
               nextState = EXEC;
            end
         end
         EXEC: begin
            case (curKind)
               K_BRANCH: begin branch = 1'b1; pcWriteCond = 1'b1; nextState = FETCH; end
               K_JUMP:   begin pcWrite = 1'b1; nextState = FETCH; end
               K_JAL:    begin pcWrite = 1'b1; nextState = WB; end
               K_LOAD, K_STORE: nextState = MEM;
               default:  nextState = WB;
            endcase
         end
         MEM: begin
            memReq   = 1'b1;
            memRead  = (curKind == K_LOAD);
            memWrite = (curKind == K_STORE);
            if (mem_ready_i) begin
               nextState = (curKind == K_LOAD) ? WB : FETCH;
            end else if (expired) begin
               memReq    = 1'b0;
               memRead   = 1'b0;
               memWrite  = 1'b0;
               timeout   = 1'b1;
               nextState = FETCH;
            end else begin
               nextWait = waitCnt + 1'b1;
            end
         end
         WB: begin
            regWrite  = 1'b1;
            nextState = FETCH;
         end
         default: nextState = FETCH;
      endcase
      // decoded fields read 0 once the instruction is finished
      if (nextState == FETCH) begin
         nextOp    = '0;
         nextFunct = '0;
      end
   end

   assign mem_req_o       = rst_i & memReq;
   assign ir_write_o      = rst_i & irWrite;
   assign pc_write_o      = rst_i & pcWrite;
   assign pc_write_cond_o = rst_i & pcWriteCond;
   assign RegWrite_o      = rst_i & regWrite;
   assign Branch_o        = rst_i & branch;
   assign MemRead_o       = rst_i & memRead;
   assign MemWrite_o      = rst_i & memWrite;
   assign illegal_o       = rst_i & illegal;
   assign timeout_o       = rst_i & timeout;
   assign ALU_op_o        = (rst_i && fieldsActive) ? curFields.aluOp      : '0;
   assign ALUSrc_o        = rst_i && fieldsActive && curFields.aluSrc;
   assign RegDst_o        = (rst_i && fieldsActive) ? curFields.regDst     : 2'd0;
   assign BranchType_o    = (rst_i && fieldsActive) ? curFields.branchType : 2'd0;
   assign Jump_o          = (rst_i && fieldsActive) ? curFields.jump       : 2'd0;
   assign MemToReg_o      = (rst_i && fieldsActive) ? curFields.memToReg   : 2'd0;
   assign state_o         = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: a table of single instructions with hand-derived
// totals, two hand sequences (reset during sw, timeouts) and random
// instructions, all checked cycle by cycle against a trace model.
module tb_multicycle_ctrl;

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b0;
   logic [5:0] instrOp = '0, instrFunct = '0;
   logic       memReady = 1'b0;
   logic       mem_req_o, ir_write_o, pc_write_o, pc_write_cond_o, RegWrite_o;
   logic [2:0] ALU_op_o;
   logic       ALUSrc_o;
   logic [1:0] RegDst_o;
   logic       Branch_o;
   logic [1:0] BranchType_o, Jump_o;
   logic       MemRead_o, MemWrite_o;
   logic [1:0] MemToReg_o;
   logic       illegal_o, timeout_o;
   logic [2:0] state_o;

   multicycle_ctrl dut (
      .clk_i(clk_i), .rst_i(rst_i), .instr_op_i(instrOp), .instr_funct_i(instrFunct),
      .mem_ready_i(memReady), .mem_req_o(mem_req_o), .ir_write_o(ir_write_o),
      .pc_write_o(pc_write_o), .pc_write_cond_o(pc_write_cond_o), .RegWrite_o(RegWrite_o),
      .ALU_op_o(ALU_op_o), .ALUSrc_o(ALUSrc_o), .RegDst_o(RegDst_o), .Branch_o(Branch_o),
      .BranchType_o(BranchType_o), .Jump_o(Jump_o), .MemRead_o(MemRead_o),
      .MemWrite_o(MemWrite_o), .MemToReg_o(MemToReg_o), .illegal_o(illegal_o),
      .timeout_o(timeout_o), .state_o(state_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic [2:0] st;
      logic req, irw, pcw, pcc, rw;
      logic [2:0] alu;
      logic src;
      logic [1:0] dst;
      logic br;
      logic [1:0] bt, jmp;
      logic mrd, mwr;
      logic [1:0] m2r;
      logic ill, to;
   } obs_t;

   typedef struct {
      logic       rdy;
      logic [5:0] op, funct;
      obs_t       exp;
   } step_t;

   typedef enum {K_ALU, K_BR, K_J, K_JAL, K_LW, K_SW, K_BAD} kind_e;

   typedef struct {
      string      nm;
      logic [5:0] op, funct;
      int         fw, mw, nNonF, nRw, nPc, nCond, nIll, nTo;
      logic [2:0] alu;
      logic       src;
      logic [1:0] dst, bt, jmp, m2r;
   } vec_t;

   obs_t  act;
   step_t tq[$];
   int    total = 0, bad = 0;
   int    nNonF, nRw, nPc, nCond, nIll, nTo;
   logic [2:0] cAlu;
   logic       cSrc;
   logic [1:0] cDst, cBt, cJmp, cM2r;

   assign act = {state_o, mem_req_o, ir_write_o, pc_write_o, pc_write_cond_o, RegWrite_o,
                 ALU_op_o, ALUSrc_o, RegDst_o, Branch_o, BranchType_o, Jump_o,
                 MemRead_o, MemWrite_o, MemToReg_o, illegal_o, timeout_o};

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, got, want);
      end
   endtask

   // Instruction class and its control fields, straight from the opcode table.
   function automatic void classify(input logic [5:0] op, input logic [5:0] funct,
                                    output kind_e k, output obs_t f);
      f = '0;
      k = K_BAD;
      case (op)
         6'h00: begin f.alu = 3'b010; f.dst = 2'd1;
                   if (funct == 6'h08) begin f.jmp = 2'd2; k = K_J; end else k = K_ALU; end
         6'h01: begin f.alu = 3'b001; f.bt = 2'd2; k = K_BR; end
         6'h04: begin f.alu = 3'b001; f.bt = 2'd0; k = K_BR; end
         6'h05: begin f.alu = 3'b001; f.bt = 2'd3; k = K_BR; end
         6'h06: begin f.alu = 3'b001; f.bt = 2'd1; k = K_BR; end
         6'h02: begin f.jmp = 2'd1; k = K_J; end
         6'h03: begin f.jmp = 2'd1; f.dst = 2'd2; f.m2r = 2'd2; k = K_JAL; end
         6'h08, 6'h0f: begin f.alu = 3'b100; f.src = 1'b1; k = K_ALU; end
         6'h09: begin f.alu = 3'b101; f.src = 1'b1; k = K_ALU; end
         6'h23: begin f.alu = 3'b100; f.src = 1'b1; f.m2r = 2'd1; k = K_LW; end
         6'h2b: begin f.alu = 3'b100; f.src = 1'b1; k = K_SW; end
         default: k = K_BAD;
      endcase
   endfunction

   // Off-DECODE cycles get junk opcode/ready to show they are ignored.
   task automatic push(input logic rdy, input bit isDec, input logic [5:0] op,
                       input logic [5:0] funct, input obs_t e);
      step_t s;
      s.rdy   = rdy;
      s.op    = isDec ? op : 6'($urandom);
      s.funct = isDec ? funct : 6'($urandom);
      s.exp   = e;
      tq.push_back(s);
   endtask

   // Expected per-cycle trace of one instruction: fw / mw are the number of
   // not-ready cycles before the memory answers in FETCH / MEM (>15 = never).
   task automatic genTrace(input logic [5:0] op, input logic [5:0] funct,
                           input int fw, input int mw);
      kind_e k;
      obs_t  f, e;
      classify(op, funct, k, f);
      tq.delete();
      for (int c = 0; c <= ((fw > 15) ? 15 : fw); c++) begin
         e = '0; e.req = 1'b1; e.mrd = 1'b1;
         if (c == fw) begin e.irw = 1'b1; e.pcw = 1'b1; end
         else if (c == 15) begin e.req = 1'b0; e.mrd = 1'b0; e.to = 1'b1; end
         push(c == fw, 1'b0, op, funct, e);
      end
      if (fw > 15) return;
      e = '0; e.st = 3'd1; e.ill = (k == K_BAD);
      push(1'($urandom), 1'b1, op, funct, e);
      if (k == K_BAD) return;
      e = f; e.st = 3'd2;
      if (k == K_BR) begin e.br = 1'b1; e.pcc = 1'b1; end
      if (k == K_J || k == K_JAL) e.pcw = 1'b1;
      push(1'($urandom), 1'b0, op, funct, e);
      if (k == K_BR || k == K_J) return;
      if (k == K_LW || k == K_SW) begin
         for (int c = 0; c <= ((mw > 15) ? 15 : mw); c++) begin
            e = f; e.st = 3'd3; e.req = 1'b1;
            e.mrd = (k == K_LW); e.mwr = (k == K_SW);
            if (c != mw && c == 15) begin e.req = 1'b0; e.mrd = 1'b0; e.mwr = 1'b0; e.to = 1'b1; end
            push(c == mw, 1'b0, op, funct, e);
         end
         if (mw > 15 || k == K_SW) return;
      end
      e = f; e.st = 3'd4; e.rw = 1'b1;
      push(1'($urandom), 1'b0, op, funct, e);
   endtask

   // Apply the first n steps of tq; caller is just past a rising edge.
   task automatic runTrace(input string nm, input int n, input bit endChk);
      nNonF = 0; nRw = 0; nPc = 0; nCond = 0; nIll = 0; nTo = 0;
      cAlu = '0; cSrc = 1'b0; cDst = '0; cBt = '0; cJmp = '0; cM2r = '0;
      for (int i = 0; i < n && i < tq.size(); i++) begin
         memReady = tq[i].rdy; instrOp = tq[i].op; instrFunct = tq[i].funct;
         @(negedge clk_i);
         chk($sformatf("%s.cyc%0d", nm, i), 32'(act), 32'(tq[i].exp));
         nNonF += (state_o != 3'd0); nRw += RegWrite_o; nPc += pc_write_o;
         nCond += pc_write_cond_o; nIll += illegal_o; nTo += timeout_o;
         if (state_o == 3'd2) begin
            cAlu = ALU_op_o; cSrc = ALUSrc_o; cDst = RegDst_o;
            cBt = BranchType_o; cJmp = Jump_o; cM2r = MemToReg_o;
         end
         @(posedge clk_i); #1;
      end
      if (endChk) chk({nm, ".end"}, 32'(state_o), 32'd0);
   endtask

   vec_t tbl[16];
   logic [5:0] opPool[13];

   initial begin
      //         name     op     fn     fw  mw nonF rw pc cnd ill to alu   src dst bt jmp m2r
      tbl[0]  = '{"addi",  6'h08, 6'h00, 0,  0, 3, 1, 1, 0, 0, 0, 3'd4, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0};
      tbl[1]  = '{"lw",    6'h23, 6'h00, 0,  3, 7, 1, 1, 0, 0, 0, 3'd4, 1'b1, 2'd0, 2'd0, 2'd0, 2'd1};
      tbl[2]  = '{"jal",   6'h03, 6'h00, 0,  0, 3, 1, 2, 0, 0, 0, 3'd0, 1'b0, 2'd2, 2'd0, 2'd1, 2'd2};
      tbl[3]  = '{"jr",    6'h00, 6'h08, 0,  0, 2, 0, 2, 0, 0, 0, 3'd2, 1'b0, 2'd1, 2'd0, 2'd2, 2'd0};
      tbl[4]  = '{"ble",   6'h06, 6'h00, 0,  0, 2, 0, 1, 1, 0, 0, 3'd1, 1'b0, 2'd0, 2'd1, 2'd0, 2'd0};
      tbl[5]  = '{"bltz",  6'h01, 6'h00, 0,  0, 2, 0, 1, 1, 0, 0, 3'd1, 1'b0, 2'd0, 2'd2, 2'd0, 2'd0};
      tbl[6]  = '{"beq",   6'h04, 6'h00, 1,  0, 2, 0, 1, 1, 0, 0, 3'd1, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0};
      tbl[7]  = '{"bne",   6'h05, 6'h00, 0,  0, 2, 0, 1, 1, 0, 0, 3'd1, 1'b0, 2'd0, 2'd3, 2'd0, 2'd0};
      tbl[8]  = '{"illeg", 6'h3f, 6'h00, 0,  0, 1, 0, 1, 0, 1, 0, 3'd0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0};
      tbl[9]  = '{"sw",    6'h2b, 6'h00, 1,  2, 5, 0, 1, 0, 0, 0, 3'd4, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0};
      tbl[10] = '{"radd",  6'h00, 6'h20, 0,  0, 3, 1, 1, 0, 0, 0, 3'd2, 1'b0, 2'd1, 2'd0, 2'd0, 2'd0};
      tbl[11] = '{"fto",   6'h08, 6'h00, 20, 0, 0, 0, 0, 0, 0, 1, 3'd0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0};
      tbl[12] = '{"sltiu", 6'h09, 6'h00, 0,  0, 3, 1, 1, 0, 0, 0, 3'd5, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0};
      tbl[13] = '{"j",     6'h02, 6'h00, 0,  0, 2, 0, 2, 0, 0, 0, 3'd0, 1'b0, 2'd0, 2'd0, 2'd1, 2'd0};
      tbl[14] = '{"luilim",6'h0f, 6'h00, 15, 0, 3, 1, 1, 0, 0, 0, 3'd4, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0};
      tbl[15] = '{"lwto",  6'h23, 6'h00, 0, 16,18, 0, 1, 0, 0, 1, 3'd4, 1'b1, 2'd0, 2'd0, 2'd0, 2'd1};
      opPool = '{6'h00, 6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06,
                 6'h08, 6'h09, 6'h0f, 6'h23, 6'h2b};

      // reset state
      memReady = 1'b1;
      #12 chk("reset", 32'(act), 32'd0);
      @(posedge clk_i); #1 rst_i = 1'b1;

      // table-driven single instructions
      foreach (tbl[i]) begin
         genTrace(tbl[i].op, tbl[i].funct, tbl[i].fw, tbl[i].mw);
         runTrace(tbl[i].nm, tq.size(), 1'b1);
         chk({tbl[i].nm, ".nonfetch"}, 32'(nNonF), 32'(tbl[i].nNonF));
         chk({tbl[i].nm, ".regwr"},    32'(nRw),   32'(tbl[i].nRw));
         chk({tbl[i].nm, ".pcwr"},     32'(nPc),   32'(tbl[i].nPc));
         chk({tbl[i].nm, ".pccond"},   32'(nCond), 32'(tbl[i].nCond));
         chk({tbl[i].nm, ".illegal"},  32'(nIll),  32'(tbl[i].nIll));
         chk({tbl[i].nm, ".timeout"},  32'(nTo),   32'(tbl[i].nTo));
         chk({tbl[i].nm, ".fields"}, 32'({cAlu, cSrc, cDst, cBt, cJmp, cM2r}),
             32'({tbl[i].alu, tbl[i].src, tbl[i].dst, tbl[i].bt, tbl[i].jmp, tbl[i].m2r}));
      end

      // reset in the middle of a stalled sw: everything drops at once
      genTrace(6'h2b, 6'h00, 0, 10);
      runTrace("swrst", 5, 1'b0);
      memReady = 1'b0;
      #2 rst_i = 1'b0;
      #1 chk("swrst.async", 32'(act), 32'd0);
      @(posedge clk_i); #1 chk("swrst.held", 32'(act), 32'd0);
      rst_i = 1'b1;
      genTrace(6'h08, 6'h00, 0, 0);
      runTrace("afterrst", tq.size(), 1'b1);

      // random instructions and memory latencies
      for (int n = 0; n < 40; n++) begin
         logic [5:0] op, fn;
         int fw, mw, r;
         op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : opPool[$urandom_range(0, 12)];
         fn = ($urandom_range(0, 2) == 0) ? 6'h08 : 6'($urandom);
         r  = $urandom_range(0, 9);
         fw = (r < 7) ? $urandom_range(0, 2) : (r == 7) ? 15 : (r == 8) ? 16 : $urandom_range(0, 4);
         r  = $urandom_range(0, 9);
         mw = (r < 6) ? $urandom_range(0, 3) : (r == 6) ? 15 : (r == 7) ? 17 : $urandom_range(4, 8);
         genTrace(op, fn, fw, mw);
         runTrace($sformatf("rnd%0d_op%0h", n, op), tq.size(), 1'b1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no end want end");
      $fatal(1);
   end

endmodule
